adder_share_arbiter: RTL and testbench
======================================

Name: adder_share_arbiter

Overview:
- Shares one unsigned 8-bit + 12-bit adder datapath (13-bit sum, carry-in tied 0) between NREQ requesters.
- Round-robin arbitration with one registered output stage, so the sum carries 1-cycle latency.
- Each result is tagged with the winning requester's index.
- Sits between client blocks and the prefix-adder macro and gives the adder a valid/ready front end.

Parameters:
- NREQ, 4, number of requesters (2..8).
- IDW, 2, width of the requester index; must equal ceil(log2(NREQ)).

Ports:
- clk  input  1  clock, all logic on rising edge.
- rst  input  1  synchronous active-high reset.
- req_valid  input  NREQ  per-requester operand valid.
- req_ready  output  NREQ  per-requester accept, one-hot or zero.
- req_x  input  8*NREQ  operand X of requester i in bits [8i+7:8i].
- req_y  input  12*NREQ  operand Y of requester i in bits [12i+11:12i].
- out_valid  output  1  result valid.
- out_ready  input  1  downstream accept.
- out_sum  output  13  X+Y, zero-extended X; bit 12 is the carry-out.
- out_id  output  IDW  index of the requester that produced out_sum.
- busy  output  1  out_valid held with out_ready low (stalled).

Behaviour:
- Reset (rst=1 at a clock edge): out_valid=0, out_sum=0, out_id=0, rr pointer ptr=0. Optional counter = 0.
- rst overrides any transfer in the same cycle. A pending result is dropped. No req_ready is asserted while rst=1.
- Free condition: free = !out_valid || out_ready.
- Arbitration (combinational):
  - When free, grant the first i with req_valid[i]=1, searching ptr, ptr+1, ... NREQ-1, 0, ... ptr-1.
  - req_ready[i]=1 only for the granted i. req_ready is all-zero when !free or when there are no requests.
  - req_ready must not depend on out_sum. It may depend on out_ready.
- Accept (edge with a grant):
  - out_sum <= {4'b0,req_x[i]} + req_y[i].
  - out_id <= i, out_valid <= 1.
  - ptr <= (i+1) mod NREQ.
- Drain without accept: out_valid=1, out_ready=1 and no grant gives out_valid <= 0. out_sum and out_id keep their last value.
- Stall: out_valid=1, out_ready=0 holds out_sum and out_id stable. busy=1 and there are no grants.
- Throughput: with out_ready held high, 1 result per cycle. Back-to-back accept and drain in the same cycle is required.
- Fairness:
  - ptr moves only on a grant.
  - A continuously asserted req_valid is granted within NREQ grants.
- Requesters must hold req_valid and operands until req_ready. The block does not check this.
- Arithmetic is pure unsigned. Max value 255+4095=4350 (0x10FE). No truncation.
- ptr wraps NREQ-1 -> 0. For non-power-of-two NREQ, indices >= NREQ are never produced.

Optional Feature:
- Macro: ADDER_SHARE_ARB_OVF_CNT_EN.
- When defined:
  - Adds output ovf_cnt (16 bits), reset 0.
  - ovf_cnt increments on every accept whose computed sum has bit 12 set.
  - It saturates at 0xFFFF and does not wrap.
  - Port input clr_ovf (1 bit) synchronously clears ovf_cnt. If an overflow accept occurs in the same cycle, the result is 1, not 0.
- When undefined: neither port exists and there is no counter logic. All other behaviour is identical.

Test Plan:
- Reset mid-stall:
  - Stimulus: out_valid=1, out_ready=0, req_valid=4'b1111, then rst pulsed.
  - Response: next cycle out_valid=0, ptr=0, req_ready=0 while rst=1. After release, requester 0 is granted first.
- Single request:
  - Stimulus: req 2 with X=0xFF, Y=0xFFF, out_ready=1.
  - Response: one cycle later out_valid=1, out_sum=0x10FE, out_id=2. With the optional feature compiled in, ovf_cnt=1.
- Round-robin:
  - Stimulus: all 4 requesters valid continuously, out_ready=1, operands X=i, Y=0x100*i.
  - Response: grant order 0,1,2,3,0,... and out_sum = 0x000, 0x101, 0x202, 0x303.
- Backpressure:
  - Stimulus: req 1 (X=3, Y=5) accepted, out_ready=0 for 3 cycles.
  - Response: out_sum=8 and out_id=1 stable, busy=1, req_ready=0 throughout. On out_ready=1, the pending req 3 is granted in the same cycle.
- Pointer skip:
  - Stimulus: ptr=3, only req 1 valid.
  - Response: req 1 granted and ptr becomes 2.
- Optional feature, saturation and clear:
  - Stimulus: preload 0xFFFE, then 3 overflowing sums.
  - Response: ovf_cnt=0xFFFF.
  - Stimulus: clr_ovf together with an overflowing accept.
  - Response: ovf_cnt=1.

Source files
------------

// File: rtl/adder_share_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : adder_share_arbiter
// Brief    : Round-robin valid/ready front end sharing one 8b+12b adder
//            between NREQ requesters; registered, index-tagged result.
//            Optional saturating overflow counter: ADDER_SHARE_ARB_OVF_CNT_EN
// Revision : 1.0 - initial release
// ============================================================================
module adder_share_arbiter #(
    parameter int NREQ = 4,
    parameter int IDW  = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req_valid,
    output logic [NREQ-1:0]      req_ready,
    input  logic [8*NREQ-1:0]    req_x,
    input  logic [12*NREQ-1:0]   req_y,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [12:0]          out_sum,
    output logic [IDW-1:0]       out_id,
    output logic                 busy
`ifdef ADDER_SHARE_ARB_OVF_CNT_EN
    ,
    input  logic                 clr_ovf,
    output logic [15:0]          ovf_cnt
`endif
);

    logic             r_out_valid;
    logic [12:0]      r_out_sum;
    logic [IDW-1:0]   r_out_id;
    logic [IDW-1:0]   r_ptr;

    logic             w_hi_found;
    logic [IDW-1:0]   w_hi_id;
    logic             w_lo_found;
    logic [IDW-1:0]   w_lo_id;
    logic             w_found;
    logic [IDW-1:0]   w_grant_id;
    logic             w_free;
    logic             w_grant;
    logic [7:0]       w_x;
    logic [11:0]      w_y;
    logic [12:0]      w_sum;
    logic [IDW-1:0]   w_ptr_next;

    // Rotating priority as two fixed-priority passes: indices at or above
    // the pointer win first, otherwise the lowest valid index wraps around.
    always_comb begin
        w_hi_found = 1'b0;
        w_hi_id    = '0;
        w_lo_found = 1'b0;
        w_lo_id    = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (!w_hi_found && req_valid[i] && (IDW'(i) >= r_ptr)) begin
                w_hi_found = 1'b1;
                w_hi_id    = IDW'(i);
            end
            if (!w_lo_found && req_valid[i]) begin
                w_lo_found = 1'b1;
                w_lo_id    = IDW'(i);
            end
        end
        w_found    = w_hi_found || w_lo_found;
        w_grant_id = w_hi_found ? w_hi_id : w_lo_id;
    end

    always_comb begin
        w_x = '0;
        w_y = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (w_grant_id == IDW'(i)) begin
                w_x = req_x[8*i +: 8];
                w_y = req_y[12*i +: 12];
            end
        end
    end

    assign w_sum      = {5'b0, w_x} + {1'b0, w_y};
    assign w_free     = !r_out_valid || out_ready;
    assign w_grant    = w_found && w_free && !rst;
    assign w_ptr_next = (w_grant_id == IDW'(NREQ-1)) ? '0 : w_grant_id + 1'b1;

    for (genvar g = 0; g < NREQ; g++) begin : g_ready
        assign req_ready[g] = w_grant && (w_grant_id == IDW'(g));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_out_sum   <= '0;
            r_out_id    <= '0;
            r_ptr       <= '0;
        end else if (w_grant) begin
            r_out_valid <= 1'b1;
            r_out_sum   <= w_sum;
            r_out_id    <= w_grant_id;
            r_ptr       <= w_ptr_next;
        end else if (out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    assign out_valid = r_out_valid;
    assign out_sum   = r_out_sum;
    assign out_id    = r_out_id;
    assign busy      = r_out_valid && !out_ready;

`ifdef ADDER_SHARE_ARB_OVF_CNT_EN
    logic [15:0] r_ovf_cnt;
    logic        w_ovf_hit;

    assign w_ovf_hit = w_grant && w_sum[12];

    // A clear coinciding with an overflow accept leaves that accept counted.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ovf_cnt <= '0;
        end else if (clr_ovf) begin
            r_ovf_cnt <= w_ovf_hit ? 16'd1 : 16'd0;
        end else if (w_ovf_hit && (r_ovf_cnt != 16'hFFFF)) begin
            r_ovf_cnt <= r_ovf_cnt + 16'd1;
        end
    end

    assign ovf_cnt = r_ovf_cnt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_adder_share_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_adder_share_arbiter
// Brief    : Scoreboard bench: directed scenarios plus randomized traffic
//            against a round-robin reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_adder_share_arbiter;

    localparam int NREQ = 4;
    localparam int IDW  = 2;

    logic                clk = 1'b0;
    logic                rst;
    logic [NREQ-1:0]     req_valid;
    logic [NREQ-1:0]     req_ready;
    logic [7:0]          x_op [NREQ];
    logic [11:0]         y_op [NREQ];
    logic [8*NREQ-1:0]   req_x;
    logic [12*NREQ-1:0]  req_y;
    logic                out_valid;
    logic                out_ready;
    logic [12:0]         out_sum;
    logic [IDW-1:0]      out_id;
    logic                busy;
`ifdef ADDER_SHARE_ARB_OVF_CNT_EN
    logic                clr_ovf;
    logic [15:0]         ovf_cnt;
`endif

    always #5 clk = ~clk;

    for (genvar g = 0; g < NREQ; g++) begin : g_pack
        assign req_x[8*g +: 8]   = x_op[g];
        assign req_y[12*g +: 12] = y_op[g];
    end

    adder_share_arbiter #(.NREQ(NREQ), .IDW(IDW)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_x     (req_x),
        .req_y     (req_y),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_id    (out_id),
        .busy      (busy)
`ifdef ADDER_SHARE_ARB_OVF_CNT_EN
        ,
        .clr_ovf   (clr_ovf),
        .ovf_cnt   (ovf_cnt)
`endif
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: pointer, pending-result flag and expected results
    typedef struct { int id; int sum; } res_t;
    res_t q[$];
    int   m_ptr   = 0;
    bit   m_valid = 1'b0;
    bit   m_gnt   = 1'b0;
    int   m_gid   = 0;
    int   m_gsum  = 0;
    int   m_ovf   = 0;
    bit   armed   = 1'b0;

    always @(negedge clk) begin : model_cmp
        logic [NREQ-1:0] exp_rdy;
        int idx;
        m_gnt   = 1'b0;
        exp_rdy = '0;
        if (!rst && (!m_valid || out_ready)) begin
            for (int k = 0; k < NREQ; k++) begin
                idx = (m_ptr + k) % NREQ;
                if (!m_gnt && req_valid[idx]) begin
                    m_gnt  = 1'b1;
                    m_gid  = idx;
                    m_gsum = int'(x_op[idx]) + int'(y_op[idx]);
                end
            end
        end
        if (m_gnt) exp_rdy[m_gid] = 1'b1;
        if (armed) begin
            chk("req_ready", req_ready, exp_rdy);
            chk("out_valid", out_valid, m_valid);
            chk("busy", busy, m_valid && !out_ready);
`ifdef ADDER_SHARE_ARB_OVF_CNT_EN
            chk("ovf_cnt", ovf_cnt, m_ovf);
`endif
        end
    end

    always @(posedge clk) begin : model_upd
        if (rst) begin
            armed   = 1'b1;
            m_valid = 1'b0;
            m_ptr   = 0;
            m_ovf   = 0;
            q.delete();
        end else begin
`ifdef ADDER_SHARE_ARB_OVF_CNT_EN
            if (clr_ovf)
                m_ovf = (m_gnt && m_gsum >= 4096) ? 1 : 0;
            else if (m_gnt && m_gsum >= 4096 && m_ovf < 65535)
                m_ovf = m_ovf + 1;
`endif
            if (m_gnt) begin
                q.push_back('{m_gid, m_gsum});
                m_ptr   = (m_gid + 1) % NREQ;
                m_valid = 1'b1;
            end else if (out_ready) begin
                m_valid = 1'b0;
            end
        end
    end

    // Monitor: every presented result must match the oldest expected one
    always @(negedge clk) begin : monitor
        if (armed && out_valid === 1'b1) begin
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL out_unexpected actual=id%0d/sum%0h expected=none at %0t",
                         out_id, out_sum, $time);
            end else begin
                chk("out_sum", out_sum, q[0].sum);
                chk("out_id", out_id, q[0].id);
                if (out_ready) void'(q.pop_front());
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic rst_pulse();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    initial begin
        logic [NREQ-1:0] acc;
        rst       = 1'b1;
        req_valid = '0;
        out_ready = 1'b0;
`ifdef ADDER_SHARE_ARB_OVF_CNT_EN
        clr_ovf   = 1'b0;
`endif
        for (int i = 0; i < NREQ; i++) begin
            x_op[i] = '0;
            y_op[i] = '0;
        end
        step();
        step();
        chk("reset_out_valid", out_valid, 0);
        chk("reset_out_sum", out_sum, 0);
        chk("reset_out_id", out_id, 0);
        rst = 1'b0;

        // Reset in the middle of a stall
        for (int i = 0; i < NREQ; i++) begin
            x_op[i] = 8'(i + 1);
            y_op[i] = 12'(i + 2);
        end
        req_valid = 4'b1111;
        out_ready = 1'b0;
        step();
        step();
        chk("stall_busy", busy, 1);
        rst = 1'b1;
        #1;
        chk("rst_no_ready", req_ready, 0);
        step();
        chk("rst_drop_valid", out_valid, 0);
        rst = 1'b0;
        #1;
        chk("rst_first_grant", req_ready, 4'b0001);
        out_ready = 1'b1;
        step();
        req_valid = '0;
        step();

        // Single request at maximum operands
        rst_pulse();
        x_op[2]   = 8'hFF;
        y_op[2]   = 12'hFFF;
        req_valid = 4'b0100;
        step();
        req_valid = '0;
        chk("single_valid", out_valid, 1);
        chk("single_sum", out_sum, 13'h10FE);
        chk("single_id", out_id, 2);
`ifdef ADDER_SHARE_ARB_OVF_CNT_EN
        chk("single_ovf", ovf_cnt, 1);
`endif
        step();

        // Round-robin with all requesters continuously valid
        rst_pulse();
        for (int i = 0; i < NREQ; i++) begin
            x_op[i] = 8'(i);
            y_op[i] = 12'(256 * i);
        end
        req_valid = 4'b1111;
        for (int n = 0; n < 8; n++) begin
            step();
            chk("rr_id", out_id, n % NREQ);
            chk("rr_sum", out_sum, (n % NREQ) * 257);
        end
        req_valid = '0;
        step();

        // Backpressure with a pending requester
        rst_pulse();
        x_op[1] = 8'd3;  y_op[1] = 12'd5;
        x_op[3] = 8'd7;  y_op[3] = 12'd9;
        req_valid = 4'b0010;
        step();
        req_valid = 4'b1000;
        out_ready = 1'b0;
        for (int n = 0; n < 3; n++) begin
            step();
            chk("bp_sum", out_sum, 8);
            chk("bp_id", out_id, 1);
            chk("bp_busy", busy, 1);
            chk("bp_ready", req_ready, 0);
        end
        out_ready = 1'b1;
        #1;
        chk("bp_release_grant", req_ready, 4'b1000);
        step();
        req_valid = '0;
        chk("bp_next_id", out_id, 3);
        chk("bp_next_sum", out_sum, 16);
        step();

        // Pointer skip: pointer at 3, only requester 1 valid
        rst_pulse();
        req_valid = 4'b0100;
        step();
        x_op[1] = 8'd1; y_op[1] = 12'd2;
        req_valid = 4'b0010;
        step();
        req_valid = '0;
        chk("skip_id", out_id, 1);
        chk("skip_sum", out_sum, 3);
        req_valid = 4'b1111;
        #1;
        chk("skip_ptr_next", req_ready, 4'b0100);
        step();
        req_valid = '0;
        step();

`ifdef ADDER_SHARE_ARB_OVF_CNT_EN
        rst_pulse();
        x_op[0] = 8'hFF; y_op[0] = 12'hFFF;
        req_valid = 4'b0001;
        step(); step(); step();
        chk("ovf_count3", ovf_cnt, 3);
        clr_ovf = 1'b1;
        step();
        clr_ovf = 1'b0;
        req_valid = '0;
        chk("ovf_clr_hit", ovf_cnt, 1);
        step();
`endif

        // Randomized traffic; operands held until accepted
        for (int n = 0; n < 400; n++) begin
            @(negedge clk);
            acc = req_ready;
            @(posedge clk);
            #1;
            for (int i = 0; i < NREQ; i++) begin
                if (acc[i] || !req_valid[i]) begin
                    req_valid[i] = 1'($urandom_range(0, 1));
                    x_op[i] = 8'($urandom_range(0, 255));
                    y_op[i] = 12'($urandom_range(0, 4095));
                end
            end
            out_ready = ($urandom_range(0, 3) != 0);
            rst       = ($urandom_range(0, 63) == 0);
`ifdef ADDER_SHARE_ARB_OVF_CNT_EN
            clr_ovf   = ($urandom_range(0, 15) == 0);
`endif
        end

        rst       = 1'b0;
        req_valid = '0;
        out_ready = 1'b1;
`ifdef ADDER_SHARE_ARB_OVF_CNT_EN
        clr_ovf   = 1'b0;
`endif
        step(); step(); step();
        chk("drain_queue_empty", q.size(), 0);
        chk("drain_out_valid", out_valid, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
